// File: rtl/alu8_pkg.sv
// Shared types and constants for the alu8 front-end arbiter.
package alu8_pkg;

    localparam int unsigned DATA_W      = 8;
    localparam int unsigned MAX_LATENCY = 15;
    localparam int unsigned CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESPOND
    } state_t;

    typedef logic port_id_t;

    typedef struct packed {
        logic [DATA_W-1:0] opcode;
        logic [DATA_W-1:0] lhs;
        logic [DATA_W-1:0] rhs;
    } alu_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins, otherwise prio decides.
module rr_arbiter2
    import alu8_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       prio,
    output logic       grant_c,
    output logic       grant_valid_c
);

    always_comb begin
        grant_valid_c = |valid;
        grant_c       = prio;
        if (valid == 2'b01) begin
            grant_c = 1'b0;
        end else if (valid == 2'b10) begin
            grant_c = 1'b1;
        end
    end

endmodule

// File: rtl/alu8_arbiter.sv
// Shares one alu8 between two requesters; one operation in flight at a time.
module alu8_arbiter
    import alu8_pkg::*;
#(
    parameter int unsigned ALU_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_opcode,
    input  logic [DATA_W-1:0] req0_lhs,
    input  logic [DATA_W-1:0] req0_rhs,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_opcode,
    input  logic [DATA_W-1:0] req1_lhs,
    input  logic [DATA_W-1:0] req1_rhs,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              alu_enable,
    output logic [DATA_W-1:0] alu_opcode,
    output logic [DATA_W-1:0] alu_lhs,
    output logic [DATA_W-1:0] alu_rhs,
    input  logic [DATA_W-1:0] alu_result,
    output logic              busy
);

    state_t            state_q, state_d;
    port_id_t          prio_q, prio_d;
    port_id_t          grant_q, grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    alu_req_t          op_q, op_d;
    logic [DATA_W-1:0] res0_q, res0_d, res1_q, res1_d;
    logic              enable_q, enable_d;
    logic              valid0_q, valid0_d, valid1_q, valid1_d;
    logic              busy_q, busy_d;
    logic              grant_c, grant_valid_c;
    logic              rsp_ready_sel_c;
    alu_req_t          req0_c, req1_c;

    assign req0_c = {req0_opcode, req0_lhs, req0_rhs};
    assign req1_c = {req1_opcode, req1_lhs, req1_rhs};

    rr_arbiter2 u_arb (
        .valid         ({req1_valid, req0_valid}),
        .prio          (prio_q),
        .grant_c       (grant_c),
        .grant_valid_c (grant_valid_c)
    );

    assign rsp_ready_sel_c = grant_q ? rsp1_ready : rsp0_ready;

    // Next-state and next-output decode; registered outputs are loaded from the *_d values.
    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        grant_d    = grant_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        res0_d     = res0_q;
        res1_d     = res1_q;
        enable_d   = 1'b0;
        valid0_d   = 1'b0;
        valid1_d   = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_valid_c) begin
                    req0_ready = ~grant_c;
                    req1_ready = grant_c;
                    grant_d    = grant_c;
                    op_d       = grant_c ? req1_c : req0_c;
                    enable_d   = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_W'(ALU_LATENCY - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    if (grant_q) begin
                        res1_d   = alu_result;
                        valid1_d = 1'b1;
                    end else begin
                        res0_d   = alu_result;
                        valid0_d = 1'b1;
                    end
                    state_d = RESPOND;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESPOND: begin
                if (rsp_ready_sel_c) begin
                    prio_d  = ~grant_q;
                    state_d = IDLE;
                end else begin
                    valid0_d = valid0_q;
                    valid1_d = valid1_q;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            prio_q   <= 1'b0;
            grant_q  <= 1'b0;
            cnt_q    <= '0;
            op_q     <= '0;
            res0_q   <= '0;
            res1_q   <= '0;
            enable_q <= 1'b0;
            valid0_q <= 1'b0;
            valid1_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            res0_q   <= res0_d;
            res1_q   <= res1_d;
            enable_q <= enable_d;
            valid0_q <= valid0_d;
            valid1_q <= valid1_d;
            busy_q   <= busy_d;
        end
    end

    assign alu_enable  = enable_q;
    assign alu_opcode  = op_q.opcode;
    assign alu_lhs     = op_q.lhs;
    assign alu_rhs     = op_q.rhs;
    assign rsp0_valid  = valid0_q;
    assign rsp1_valid  = valid1_q;
    assign rsp0_result = res0_q;
    assign rsp1_result = res1_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_alu8_arbiter.sv
// Bench for alu8_arbiter: two DUTs (latency 1 and 3) each against a transaction-level model.
module tb_alu8_arbiter;

    localparam int unsigned LAT0 = 1;
    localparam int unsigned LAT1 = 3;

    logic clk = 1'b0;
    logic rst_n;

    // Indexed [dut][port]
    logic       req_valid  [2][2];
    logic       req_ready  [2][2];
    logic [7:0] req_opcode [2][2];
    logic [7:0] req_lhs    [2][2];
    logic [7:0] req_rhs    [2][2];
    logic       rsp_valid  [2][2];
    logic       rsp_ready  [2][2];
    logic [7:0] rsp_result [2][2];
    logic       alu_enable [2];
    logic [7:0] alu_opcode [2];
    logic [7:0] alu_lhs    [2];
    logic [7:0] alu_rhs    [2];
    logic [7:0] alu_result [2];
    logic       busy       [2];

    int checks;
    int failures;
    logic cmp_en;

    logic [23:0] q    [2][2][$];
    int          hold [2][2];

    initial forever #5 clk = ~clk;

    alu8_arbiter #(.ALU_LATENCY(LAT0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req_valid[0][0]), .req0_ready(req_ready[0][0]),
        .req0_opcode(req_opcode[0][0]), .req0_lhs(req_lhs[0][0]), .req0_rhs(req_rhs[0][0]),
        .rsp0_valid(rsp_valid[0][0]), .rsp0_ready(rsp_ready[0][0]), .rsp0_result(rsp_result[0][0]),
        .req1_valid(req_valid[0][1]), .req1_ready(req_ready[0][1]),
        .req1_opcode(req_opcode[0][1]), .req1_lhs(req_lhs[0][1]), .req1_rhs(req_rhs[0][1]),
        .rsp1_valid(rsp_valid[0][1]), .rsp1_ready(rsp_ready[0][1]), .rsp1_result(rsp_result[0][1]),
        .alu_enable(alu_enable[0]), .alu_opcode(alu_opcode[0]), .alu_lhs(alu_lhs[0]),
        .alu_rhs(alu_rhs[0]), .alu_result(alu_result[0]), .busy(busy[0])
    );

    alu8_arbiter #(.ALU_LATENCY(LAT1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req_valid[1][0]), .req0_ready(req_ready[1][0]),
        .req0_opcode(req_opcode[1][0]), .req0_lhs(req_lhs[1][0]), .req0_rhs(req_rhs[1][0]),
        .rsp0_valid(rsp_valid[1][0]), .rsp0_ready(rsp_ready[1][0]), .rsp0_result(rsp_result[1][0]),
        .req1_valid(req_valid[1][1]), .req1_ready(req_ready[1][1]),
        .req1_opcode(req_opcode[1][1]), .req1_lhs(req_lhs[1][1]), .req1_rhs(req_rhs[1][1]),
        .rsp1_valid(rsp_valid[1][1]), .rsp1_ready(rsp_ready[1][1]), .rsp1_result(rsp_result[1][1]),
        .alu_enable(alu_enable[1]), .alu_opcode(alu_opcode[1]), .alu_lhs(alu_lhs[1]),
        .alu_rhs(alu_rhs[1]), .alu_result(alu_result[1]), .busy(busy[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? int'(LAT0) : int'(LAT1);
    endfunction

    function automatic logic [7:0] alu_f(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        case (op)
            8'd0:    r = a + b;
            8'd1:    r = a - b;
            8'd2:    r = a & b;
            8'd3:    r = a | b;
            default: r = a ^ b;
        endcase
        return r;
    endfunction

    // ALU stub: true result only in the cycle before its sample edge, inverted junk otherwise
    logic [3:0] stub_cnt [2];
    logic [7:0] stub_op  [2];
    logic [7:0] stub_lhs [2];
    logic [7:0] stub_rhs [2];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                stub_cnt[d] <= 4'd0;
                stub_op[d]  <= 8'd0;
                stub_lhs[d] <= 8'd0;
                stub_rhs[d] <= 8'd0;
            end else if (alu_enable[d]) begin
                stub_cnt[d] <= 4'(lat_of(d));
                stub_op[d]  <= alu_opcode[d];
                stub_lhs[d] <= alu_lhs[d];
                stub_rhs[d] <= alu_rhs[d];
            end else if (stub_cnt[d] != 4'd0) begin
                stub_cnt[d] <= stub_cnt[d] - 4'd1;
            end
        end
    end

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            alu_result[d] = alu_f(stub_op[d], stub_lhs[d], stub_rhs[d]);
            if (stub_cnt[d] != 4'd1) alu_result[d] = alu_result[d] ^ 8'hFF;
        end
    end

    // Transaction model: age counts cycles since the accepting edge
    logic       m_busy  [2];
    logic       m_grant [2];
    logic       m_prio  [2];
    int         m_age   [2];
    logic [7:0] m_op    [2];
    logic [7:0] m_lhs   [2];
    logic [7:0] m_rhs   [2];
    logic [7:0] m_res   [2][2];

    always @(posedge clk) begin
        logic g;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_busy[d]   <= 1'b0;
                m_grant[d]  <= 1'b0;
                m_prio[d]   <= 1'b0;
                m_age[d]    <= 0;
                m_op[d]     <= 8'd0;
                m_lhs[d]    <= 8'd0;
                m_rhs[d]    <= 8'd0;
                m_res[d][0] <= 8'd0;
                m_res[d][1] <= 8'd0;
            end else if (!m_busy[d]) begin
                if (req_valid[d][0] || req_valid[d][1]) begin
                    g = (req_valid[d][0] && req_valid[d][1]) ? m_prio[d] : req_valid[d][1];
                    m_busy[d]  <= 1'b1;
                    m_grant[d] <= g;
                    m_age[d]   <= 1;
                    m_op[d]    <= req_opcode[d][g];
                    m_lhs[d]   <= req_lhs[d][g];
                    m_rhs[d]   <= req_rhs[d][g];
                end
            end else if (m_age[d] == lat_of(d) + 1) begin
                m_res[d][m_grant[d]] <= alu_f(m_op[d], m_lhs[d], m_rhs[d]);
                m_age[d] <= m_age[d] + 1;
            end else if (m_age[d] >= lat_of(d) + 2) begin
                if (rsp_ready[d][m_grant[d]]) begin
                    m_busy[d] <= 1'b0;
                    m_prio[d] <= ~m_grant[d];
                end
            end else begin
                m_age[d] <= m_age[d] + 1;
            end
        end
    end

    function automatic logic exp_ready(input int d, input int p);
        if (m_busy[d]) return 1'b0;
        if (req_valid[d][p] && req_valid[d][1-p]) return (int'(m_prio[d]) == p);
        return req_valid[d][p];
    endfunction

    // Requester/responder driver: sample handshakes mid-cycle, update requests just after the edge
    initial begin
        logic        acc [2][2];
        logic [23:0] h;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                req_valid[d][p]  = 1'b0;
                req_opcode[d][p] = 8'd0;
                req_lhs[d][p]    = 8'd0;
                req_rhs[d][p]    = 8'd0;
                rsp_ready[d][p]  = 1'b1;
                hold[d][p]       = 0;
            end
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < 2; p++) begin
                    acc[d][p]       = req_valid[d][p] && req_ready[d][p];
                    rsp_ready[d][p] = (hold[d][p] == 0);
                    if (rsp_valid[d][p] && hold[d][p] > 0) hold[d][p] = hold[d][p] - 1;
                end
            end
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < 2; p++) begin
                    if (acc[d][p] && q[d][p].size() > 0) void'(q[d][p].pop_front());
                    if (q[d][p].size() > 0) begin
                        h = q[d][p][0];
                        req_valid[d][p]  = 1'b1;
                        req_opcode[d][p] = h[23:16];
                        req_lhs[d][p]    = h[15:8];
                        req_rhs[d][p]    = h[7:0];
                    end else begin
                        req_valid[d][p] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int d, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d actual=%0h required=%0h t=%0t", name, d, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < 2; d++) begin
            chk("busy", d, 8'(busy[d]), 8'(m_busy[d]));
            chk("alu_enable", d, 8'(alu_enable[d]), 8'(m_busy[d] && m_age[d] == 1));
            chk("alu_opcode", d, alu_opcode[d], m_op[d]);
            chk("alu_lhs", d, alu_lhs[d], m_lhs[d]);
            chk("alu_rhs", d, alu_rhs[d], m_rhs[d]);
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("req%0d_ready", p), d, 8'(req_ready[d][p]), 8'(exp_ready(d, p)));
                chk($sformatf("rsp%0d_valid", p), d, 8'(rsp_valid[d][p]),
                    8'(m_busy[d] && int'(m_grant[d]) == p && m_age[d] >= lat_of(d) + 2));
                chk($sformatf("rsp%0d_result", p), d, rsp_result[d][p], m_res[d][p]);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (cmp_en) compare_all();
    endtask

    task automatic push(input int p, input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        for (int d = 0; d < 2; d++) q[d][p].push_back({op, a, b});
    endtask

    function automatic logic all_idle();
        for (int d = 0; d < 2; d++) begin
            if (busy[d]) return 1'b0;
            for (int p = 0; p < 2; p++) begin
                if (q[d][p].size() > 0 || req_valid[d][p]) return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    task automatic drain();
        int t;
        t = 0;
        while (t < 300 && !all_idle()) begin
            tick();
            t++;
        end
        chk("drain_idle", 0, 8'(all_idle()), 8'd1);
    endtask

    initial begin
        int         n;
        int         seen;
        logic [7:0] seq;
        checks   = 0;
        failures = 0;
        cmp_en   = 1'b0;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_busy", d, 8'(busy[d]), 8'd0);
            chk("reset_alu_lhs", d, alu_lhs[d], 8'd0);
        end

        // Single op: 1 - 3 = 0xFE
        push(0, 8'd1, 8'd1, 8'd3);
        tick();
        chk("t1_req0_ready_c0", 0, 8'(req_ready[0][0]), 8'd1);
        tick();
        chk("t1_enable_c1", 0, 8'(alu_enable[0]), 8'd1);
        chk("t1_lhs_c1", 0, alu_lhs[0], 8'd1);
        chk("t1_rhs_c1", 0, alu_rhs[0], 8'd3);
        tick();
        chk("t1_enable_c2", 0, 8'(alu_enable[0]), 8'd0);
        tick();
        chk("t1_rsp0_valid_c3", 0, 8'(rsp_valid[0][0]), 8'd1);
        chk("t1_rsp0_result_c3", 0, rsp_result[0][0], 8'hFE);
        chk("t1_rsp1_valid_c3", 0, 8'(rsp_valid[0][1]), 8'd0);
        tick();
        tick();
        chk("t1_rsp0_valid_c5", 1, 8'(rsp_valid[1][0]), 8'd1);
        chk("t1_rsp0_result_c5", 1, rsp_result[1][0], 8'hFE);

        // Idle hold: operands keep last issued values
        repeat (20) tick();
        for (int d = 0; d < 2; d++) begin
            chk("t6_busy", d, 8'(busy[d]), 8'd0);
            chk("t6_enable", d, 8'(alu_enable[d]), 8'd0);
            chk("t6_opcode", d, alu_opcode[d], 8'd1);
            chk("t6_lhs", d, alu_lhs[d], 8'd1);
            chk("t6_rhs", d, alu_rhs[d], 8'd3);
        end

        // Simultaneous requests after reset: port 0 first, port 1 accepted at cycle 4
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        push(0, 8'd2, 8'hF0, 8'h3C);
        push(1, 8'd3, 8'h0F, 8'h30);
        tick();
        chk("t2_req0_ready_c0", 0, 8'(req_ready[0][0]), 8'd1);
        chk("t2_req1_ready_c0", 0, 8'(req_ready[0][1]), 8'd0);
        repeat (3) tick();
        chk("t2_rsp0_valid_c3", 0, 8'(rsp_valid[0][0]), 8'd1);
        chk("t2_rsp0_result_c3", 0, rsp_result[0][0], 8'h30);
        tick();
        chk("t2_req1_ready_c4", 0, 8'(req_ready[0][1]), 8'd1);
        repeat (3) tick();
        chk("t2_rsp1_valid_c7", 0, 8'(rsp_valid[0][1]), 8'd1);
        chk("t2_rsp1_result_c7", 0, rsp_result[0][1], 8'h3F);
        drain();

        // Continuous contention: grants alternate
        for (int i = 0; i < 4; i++) begin
            push(0, 8'd0, 8'(i), 8'd1);
            push(1, 8'd1, 8'(10 + i), 8'(i));
        end
        n   = 0;
        seq = 8'd0;
        for (int t = 0; t < 200 && n < 8; t++) begin
            tick();
            if (req_valid[0][0] && req_ready[0][0]) begin
                seq[n] = 1'b0;
                n++;
            end else if (req_valid[0][1] && req_ready[0][1]) begin
                seq[n] = 1'b1;
                n++;
            end
        end
        chk("t2_grant_count", 0, 8'(n), 8'd8);
        chk("t2_grant_order", 0, seq, 8'b1010_1010);
        drain();

        // Backpressure on port 1 for 10 cycles while port 0 waits
        push(1, 8'd0, 8'd5, 8'd6);
        tick();
        chk("t3_req1_ready_c0", 0, 8'(req_ready[0][1]), 8'd1);
        hold[0][1] = 10;
        hold[1][1] = 10;
        push(0, 8'd2, 8'hFF, 8'h0F);
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c >= 3) begin
                chk("t3_rsp1_valid_held", 0, 8'(rsp_valid[0][1]), 8'd1);
                chk("t3_rsp1_result_held", 0, rsp_result[0][1], 8'h0B);
                chk("t3_req0_blocked", 0, 8'(req_ready[0][0]), 8'd0);
            end
        end
        tick();
        chk("t3_rsp1_valid_c13", 0, 8'(rsp_valid[0][1]), 8'd1);
        tick();
        chk("t3_req0_ready_c14", 0, 8'(req_ready[0][0]), 8'd1);
        chk("t3_rsp1_valid_c14", 0, 8'(rsp_valid[0][1]), 8'd0);
        drain();

        // Latency 3: 200 + 100 = 0x2C, response at cycle 5
        push(0, 8'd0, 8'd200, 8'd100);
        repeat (4) tick();
        chk("t4_rsp0_result_lat1", 0, rsp_result[0][0], 8'h2C);
        tick();
        chk("t4_rsp0_valid_c4", 1, 8'(rsp_valid[1][0]), 8'd0);
        tick();
        chk("t4_rsp0_valid_c5", 1, 8'(rsp_valid[1][0]), 8'd1);
        chk("t4_rsp0_result_c5", 1, rsp_result[1][0], 8'h2C);
        drain();

        // Reset during WAIT drops the transaction and clears prio
        push(1, 8'd4, 8'h55, 8'hAA);
        repeat (3) tick();
        chk("t5_busy_before", 1, 8'(busy[1]), 8'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            chk("t5_busy", d, 8'(busy[d]), 8'd0);
            chk("t5_enable", d, 8'(alu_enable[d]), 8'd0);
            chk("t5_lhs", d, alu_lhs[d], 8'd0);
            chk("t5_rhs", d, alu_rhs[d], 8'd0);
            chk("t5_rsp1_valid", d, 8'(rsp_valid[d][1]), 8'd0);
        end
        seen = 0;
        repeat (10) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                if (rsp_valid[d][0] || rsp_valid[d][1]) seen++;
            end
        end
        chk("t5_no_response", 0, 8'(seen), 8'd0);
        push(0, 8'd0, 8'd7, 8'd8);
        push(1, 8'd0, 8'd9, 8'd10);
        tick();
        for (int d = 0; d < 2; d++) begin
            chk("t5_prio_req0_ready", d, 8'(req_ready[d][0]), 8'd1);
            chk("t5_prio_req1_ready", d, 8'(req_ready[d][1]), 8'd0);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
